phys_free_list: RTL and testbench
=================================

# phys_free_list

Circular FIFO of free physical register indices feeding the rename stage. Dispatch pops one new destination physical register per cycle and writes it into the map table. Retire pushes back the superseded physical register of the retiring instruction. Mispredict recovery rewinds the allocation pointer to the architectural (retired) point, so speculative allocations return to the pool in one cycle.

## Interface
Parameters:
- PHYS_REGS, 64: physical register count; power of two.
- ARCH_REGS, 32: architectural register count.
- DEPTH, PHYS_REGS-ARCH_REGS (32): FIFO entries; power of two.
- PR_W, $clog2(PHYS_REGS) (6): physical index width.
- PTR_W, $clog2(DEPTH) (5): pointer index width. Pointers carry one extra wrap bit.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- alloc_req  in  1  dispatch requests one physical register this cycle.
- alloc_valid  out  1  list non-empty; alloc fires iff alloc_req && alloc_valid && !restore_enable.
- alloc_pr  out  PR_W  entry at head; combinational from state.
- retire_enable  in  1  retiring instruction owns a destination. Its allocation becomes architectural.
- retire_old_pr  in  PR_W  superseded physical register to free.
- restore_enable  in  1  squash: discard all speculative allocations.
- free_count  out  PTR_W+1  tail − head, range 0..DEPTH.
- overflow_err  out  1  sticky; set on a push while full. Cleared only by reset.

## Operation
- Storage: DEPTH × PR_W entry array. Three pointers, each PTR_W+1 bits, in PR index space modulo 2·DEPTH:
  - head: next allocation.
  - tail: next free slot.
  - ret_head: head as seen by retired state.
- Empty and full conditions:
  - empty = (head == tail).
  - full = (tail − head == DEPTH).
  - alloc_valid = !empty.
  - alloc_pr = array[head[PTR_W-1:0]].
- Reset:
  - array[i] = ARCH_REGS + i.
  - head = ret_head = 0.
  - tail = DEPTH, so the list starts full with 32 entries.
  - overflow_err = 0.
- Allocate: head += 1. Allowed only when alloc fires.
- Retire, when retire_enable:
  - ret_head += 1.
  - If retire_old_pr != 0, write array[tail] = retire_old_pr and tail += 1.
  - retire_old_pr == 0 (zero register) is never pushed.
- Push while full:
  - Drop the write and leave tail unchanged.
  - Set overflow_err.
- Restore, when restore_enable:
  - head <= ret_head + (retire_enable ? 1 : 0).
  - Any alloc_req in that cycle is ignored and the pointer does not move.
  - A retire push in the same cycle still takes effect.
- Pointer arithmetic: all pointer arithmetic wraps modulo 2·DEPTH, and the index is the low PTR_W bits. free_count is computed after wrap subtraction.

## Timing
- Allocation path:
  - alloc_pr and alloc_valid are valid combinationally in the same cycle as alloc_req.
  - Head advances at the next posedge.
  - The next entry is visible after that posedge.
- Freed register: a register freed at posedge N can be allocated in cycle N+1. There is no same-cycle bypass while empty, so a push into an empty list leaves alloc_valid=0 that cycle.
- Simultaneous alloc and retire push: head and tail both advance and free_count is unchanged. This also holds at full, because the pop makes room in the same cycle. The full check uses the pre-cycle state plus the pop in that cycle.
- Restore latency:
  - Restore takes 1 cycle; the cycle after restore_enable shows the rewound head.
  - free_count = tail − rewound head.
- Reset:
  - Reset wins over all other inputs.
  - Reset asserted mid-operation reinitialises the array and pointers at the next posedge.
  - Reset values of outputs: alloc_valid=1, alloc_pr=ARCH_REGS (32), free_count=DEPTH (32), overflow_err=0.
- Debug print: each negedge prints head, tail, ret_head, and free_count.

## Test plan
- Reset, then alloc_req held for 32 cycles → alloc_pr runs 32, 33, …, 63; free_count reaches 0; alloc_valid=0 on cycle 33.
- From empty, retire_enable with retire_old_pr=5 → alloc_valid=0 that cycle. Next cycle alloc_valid=1, alloc_pr=5, free_count=1.
- Retire_old_pr=0 with retire_enable → tail unchanged, ret_head+1, free_count unchanged.
- Alloc 3 (32, 33, 34), retire 1 freeing 7, then restore_enable → next cycle alloc_pr=33, free_count=32. Freed 7 sits at the tail.
- Restore, retire (old_pr=9), and alloc_req all in the same cycle → alloc ignored, head = old ret_head + 1, 9 pushed.
- At full (after reset), push retire_old_pr=12 without alloc → overflow_err=1 and stays 1; free_count stays 32. Same push with alloc_req → no error, alloc_pr=32 consumed.

Source files
------------

// File: rtl/phys_free_list.sv
// phys_free_list: circular FIFO of free physical register indices with retire-point rewind
module phys_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int DEPTH = PHYS_REGS - ARCH_REGS,
  parameter int PR_W = $clog2(PHYS_REGS),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [PR_W-1:0]  alloc_pr,
  input  logic             retire_enable,
  input  logic [PR_W-1:0]  retire_old_pr,
  input  logic             restore_enable,
  output logic [PTR_W:0]   free_count,
  output logic             overflow_err
);
  localparam logic [PTR_W:0] one = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] depth_p = (PTR_W+1)'(DEPTH);
  logic [PR_W-1:0] mem [DEPTH];
  logic [PTR_W:0] head, tail, ret_head;
  logic alloc_fire, push_req, push_ok, full;
  // occupancy, pop/push qualification; a same-cycle pop makes room for a push at full
  always_comb begin
    free_count = tail - head;
    full = free_count == depth_p;
    alloc_valid = head != tail;
    alloc_pr = mem[head[PTR_W-1:0]];
    alloc_fire = alloc_req && alloc_valid && !restore_enable;
    push_req = retire_enable && retire_old_pr != '0;
    push_ok = push_req && (!full || alloc_fire);
  end
  // pointer and array update; restore rewinds head to the retired point
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PR_W'(ARCH_REGS + i);
      head <= '0;
      ret_head <= '0;
      tail <= depth_p;
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[tail[PTR_W-1:0]] <= retire_old_pr;
        tail <= tail + one;
      end
      if (push_req && !push_ok) overflow_err <= 1'b1;
      if (retire_enable) ret_head <= ret_head + one;
      head <= restore_enable ? ret_head + {{PTR_W{1'b0}}, retire_enable}
            : alloc_fire ? head + one : head;
    end
  end
endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list: table-driven directed check of the free list
module tb_phys_free_list;
  logic clk = 1'b0, reset = 1'b1, alloc_req = 1'b0, retire_enable = 1'b0, restore_enable = 1'b0;
  logic [5:0] retire_old_pr = '0;
  logic alloc_valid, overflow_err;
  logic [5:0] alloc_pr;
  logic [5:0] free_count;
  int passed = 0, total = 0;
  logic done = 1'b0;
  typedef struct {
    logic rst, ar, re, rs;
    logic [5:0] op;
    logic e_v;
    logic [5:0] e_pr;
    logic [5:0] e_cnt;
    logic e_err;
    string name;
  } vec_t;
  vec_t vec[$];
  phys_free_list dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_pr(alloc_pr), .retire_enable(retire_enable), .retire_old_pr(retire_old_pr),
    .restore_enable(restore_enable), .free_count(free_count), .overflow_err(overflow_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    $display("t=%0t head=%0d tail=%0d ret_head=%0d free_count=%0d", $time, dut.head, dut.tail, dut.ret_head, free_count);
  initial begin
    #5000;
    if (!done) begin
      $display("FAIL timeout: vector run did not complete");
      $finish;
    end
  end
  function automatic void add(input logic rst, ar, re, input logic [5:0] op, input logic rs,
                              input logic ev, input logic [5:0] epr, input logic [5:0] ecnt,
                              input logic eerr, input string name);
    vec_t v;
    v.rst = rst; v.ar = ar; v.re = re; v.op = op; v.rs = rs;
    v.e_v = ev; v.e_pr = epr; v.e_cnt = ecnt; v.e_err = eerr; v.name = name;
    vec.push_back(v);
  endfunction
  initial begin
    for (int i = 0; i < 32; i++) add(0, 1, 0, 0, 0, 1, 6'(32 + i), 6'(32 - i), 0, $sformatf("drain%0d", i));
    add(0, 1, 0, 0, 0, 0, 32, 0, 0, "empty_alloc");
    add(0, 0, 1, 5, 0, 0, 32, 0, 0, "push_into_empty");
    add(0, 0, 0, 0, 0, 1, 5, 1, 0, "freed_visible");
    add(0, 0, 1, 0, 0, 1, 5, 1, 0, "retire_zero");
    add(0, 0, 0, 0, 0, 1, 5, 1, 0, "zero_not_pushed");
    add(1, 1, 1, 3, 1, 1, 5, 1, 0, "pre_reset");
    add(0, 1, 0, 0, 0, 1, 32, 32, 0, "reset_state");
    add(0, 1, 0, 0, 0, 1, 33, 31, 0, "alloc2");
    add(0, 1, 0, 0, 0, 1, 34, 30, 0, "alloc3");
    add(0, 0, 1, 7, 0, 1, 35, 29, 0, "retire7");
    add(0, 0, 0, 0, 1, 1, 35, 30, 0, "restore");
    add(0, 1, 0, 0, 0, 1, 33, 32, 0, "after_restore");
    add(0, 1, 0, 0, 0, 1, 34, 31, 0, "alloc_b");
    add(0, 1, 1, 9, 1, 1, 35, 30, 0, "restore_retire_alloc");
    add(0, 0, 0, 0, 0, 1, 34, 32, 0, "after_combo");
    add(1, 0, 0, 0, 0, 1, 34, 32, 0, "pre_reset2");
    add(0, 1, 1, 12, 0, 1, 32, 32, 0, "full_push_pop");
    add(0, 0, 0, 0, 0, 1, 33, 32, 0, "no_overflow");
    add(0, 0, 1, 12, 0, 1, 33, 32, 0, "full_push");
    add(0, 0, 0, 0, 0, 1, 33, 32, 1, "overflow_set");
    add(0, 0, 0, 0, 0, 1, 33, 32, 1, "overflow_sticky");
    add(1, 0, 0, 0, 0, 1, 33, 32, 1, "pre_reset3");
    add(0, 0, 0, 0, 0, 1, 32, 32, 0, "reset_clears_err");
    @(posedge clk);
    #1;
    total++;
    if ({alloc_valid, alloc_pr, free_count, overflow_err} !== {1'b1, 6'd32, 6'd32, 1'b0})
      $display("FAIL initial_reset: got valid=%0b pr=%0d cnt=%0d err=%0b, want valid=1 pr=32 cnt=32 err=0",
               alloc_valid, alloc_pr, free_count, overflow_err);
    else passed++;
    foreach (vec[k]) begin
      @(negedge clk);
      reset = vec[k].rst; alloc_req = vec[k].ar; retire_enable = vec[k].re;
      retire_old_pr = vec[k].op; restore_enable = vec[k].rs;
      #1;
      total++;
      if ({alloc_valid, alloc_pr, free_count, overflow_err} !== {vec[k].e_v, vec[k].e_pr, vec[k].e_cnt, vec[k].e_err})
        $display("FAIL %s: got valid=%0b pr=%0d cnt=%0d err=%0b, want valid=%0b pr=%0d cnt=%0d err=%0b",
                 vec[k].name, alloc_valid, alloc_pr, free_count, overflow_err,
                 vec[k].e_v, vec[k].e_pr, vec[k].e_cnt, vec[k].e_err);
      else passed++;
    end
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
